// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter: captures X/Y/V on start, shifts one bit per clock
// inserting the captured fill bit at the LSB, then pulses done and holds the result.
module shift_left_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             V,
   output logic [WIDTH-1:0] Z,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fill_q, fill_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Next-state, datapath and counter update
   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE accepts a new start directly so back-to-back operations skip IDLE
            if (start) begin
               z_d     = X;
               fill_d  = V;
               state_d = ST_SHIFT;
               if (Y < WIDTH_V) begin
                  cnt_d = Y[CNT_W-1:0];
               end else begin
                  cnt_d = CNT_MAX;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != CNT_ZERO) begin
               z_d   = {z_q[WIDTH-2:0], fill_q};
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         z_q     <= {WIDTH{1'b0}};
         cnt_q   <= CNT_ZERO;
         fill_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Z    = z_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: directed cases plus randomized traffic,
// compared every cycle against a timeline model built from the shift rules.
module tb_shift_left_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] X;
   logic [31:0] Y;
   logic        V;
   logic [31:0] Z;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   int done_seen = 0;

   // model: phase 0=idle, 1=running, 2=done; e = edges since accepted start
   int          m_phase = 0;
   int          m_e = 0;
   int          m_n = 0;
   logic [31:0] m_x = 32'h0;
   logic        m_v = 1'b0;
   logic [31:0] m_z = 32'h0;
   bit          m_valid = 1'b0;

   shift_left_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .V(V),
      .Z(Z), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] f_res(input logic [31:0] x, input logic v, input int k);
      logic [31:0] m;
      if (k >= 32) return {32{v}};
      m = (32'h1 << k) - 32'h1;
      return (x << k) | (v ? m : 32'h0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_valid = 1'b1;
         m_phase = 0;
         m_z     = 32'h0;
      end else if ((m_phase == 0 || m_phase == 2) && start) begin
         m_x     = X;
         m_v     = V;
         m_n     = (Y >= 32'd32) ? 32 : int'(Y);
         m_e     = 0;
         m_phase = 1;
         m_z     = X;
      end else if (m_phase == 1) begin
         m_e++;
         if (m_e == m_n + 1) m_phase = 2;
         else m_z = f_res(m_x, m_v, m_e);
      end else if (m_phase == 2) begin
         m_phase = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (done === 1'b1) done_seen++;
      if (m_valid) begin
         chk("busy", {31'h0, busy}, {31'h0, (m_phase == 1)});
         chk("done", {31'h0, done}, {31'h0, (m_phase == 2)});
         chk("z", Z, m_z);
      end
   endtask

   task automatic wait_done(input string name);
      int guard = 0;
      while (done !== 1'b1 && guard < 40) begin
         step();
         guard++;
      end
      chk({name, "_reached_done"}, {31'h0, done}, 32'h1);
   endtask

   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic v,
                        input logic [31:0] exp_z, input int exp_busy, input string name);
      int bc = 0;
      int guard = 0;
      X = x; Y = y; V = v; start = 1'b1;
      step();
      start = 1'b0;
      while (done !== 1'b1 && guard < 40) begin
         if (busy === 1'b1) bc++;
         step();
         guard++;
      end
      chk({name, "_reached_done"}, {31'h0, done}, 32'h1);
      chk({name, "_z"}, Z, exp_z);
      chk({name, "_busy_cycles"}, bc, exp_busy);
      step();
      chk({name, "_z_hold"}, Z, exp_z);
   endtask

   initial begin
      int d0;
      int sel;
      rst = 1'b1; start = 1'b0; X = 32'h0; Y = 32'h0; V = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      chk("reset_z", Z, 32'h0);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_done", {31'h0, done}, 32'h0);

      do_op(32'h00000001, 32'd4,         1'b0, 32'h00000010, 5,  "y4");
      do_op(32'hA5A5A5A5, 32'd0,         1'b1, 32'hA5A5A5A5, 1,  "y0");
      do_op(32'h00000001, 32'd31,        1'b0, 32'h80000000, 32, "y31");
      do_op(32'h12345678, 32'd40,        1'b1, 32'hFFFFFFFF, 33, "y40");
      do_op(32'h12345678, 32'hFFFFFFFF,  1'b0, 32'h00000000, 33, "ymax");

      // start while busy must be ignored
      X = 32'h0000000F; Y = 32'd3; V = 1'b1; start = 1'b1;
      step();
      X = 32'h0; Y = 32'd8; V = 1'b0;
      d0 = done_seen;
      step();
      start = 1'b0;
      repeat (8) step();
      chk("ignore_z", Z, 32'h0000007F);
      chk("ignore_done_count", done_seen - d0, 32'd1);

      // back-to-back start during DONE
      X = 32'h1; Y = 32'd1; V = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("b2b_a_done", {31'h0, done}, 32'h1);
      chk("b2b_a_z", Z, 32'h2);
      X = 32'h3; Y = 32'd2; V = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      chk("b2b_busy", {31'h0, busy}, 32'h1);
      wait_done("b2b_b");
      chk("b2b_b_z", Z, 32'h0000000F);
      step();

      // reset mid-shift aborts without a done pulse
      X = 32'h1; Y = 32'd10; V = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_z", Z, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      d0 = done_seen;
      repeat (15) step();
      chk("abort_no_done", done_seen - d0, 32'd0);
      do_op(32'h1, 32'd2, 1'b0, 32'h4, 3, "after_abort");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         X = $urandom;
         V = $urandom_range(0, 1);
         sel = $urandom_range(0, 9);
         if (sel <= 5)      Y = $urandom_range(0, 31);
         else if (sel <= 7) Y = 32'd32;
         else if (sel == 8) Y = $urandom_range(33, 100);
         else               Y = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : $urandom;
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0; start = 1'b0;
      repeat (40) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
